// File: rtl/controle_io_if.sv
`default_nettype none
// ============================================================================
// Module   : controle_io_if
// Purpose  : Request/response bundle between the control unit, the operator
//            I/O (button and switches) and the I/O sequencer.
// Revision : 1.0
// ============================================================================
interface controle_io_if #(
    parameter int IN_WIDTH = 14
);
    logic                in_req;
    logic                out_req;
    logic                halt_req;
    logic                botao;
    logic [7:0]          switches;
    logic                stall;
    logic                in_valido;
    logic                out_strobe;
    logic [IN_WIDTH-1:0] dado_in;
    logic                halted;
    logic [1:0]          estado;

    modport master (
        output in_req, out_req, halt_req, botao, switches,
        input  stall, in_valido, out_strobe, dado_in, halted, estado
    );

    modport slave (
        input  in_req, out_req, halt_req, botao, switches,
        output stall, in_valido, out_strobe, dado_in, halted, estado
    );
endinterface
`default_nettype wire

// File: rtl/controle_io.sv
`default_nettype none
// ============================================================================
// Module   : controle_io
// Purpose  : Sequences IN/OUT/HALT instructions: stalls the core until the
//            operator confirms with a debounced button, strobes the display.
// Revision : 1.0
// ============================================================================
module controle_io #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit PAUSE_ON_OUT    = 1'b0,
    parameter int IN_WIDTH        = 14
) (
    input  wire logic     clock,
    input  wire logic     reset,
    controle_io_if.slave  io
);

    localparam int             c_cnt_w   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_st_exec   = 2'd0;
    localparam logic [1:0] c_st_espera = 2'd1;
    localparam logic [1:0] c_st_libera = 2'd2;
    localparam logic [1:0] c_st_parado = 2'd3;

    logic               r_botao_m;
    logic               r_botao_s;
    logic [7:0]         r_sw_m;
    logic [7:0]         r_sw_s;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_btn_db;
    logic               r_btn_db_q;
    logic               w_btn_press;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_tipo_in;
    logic                w_tipo_nxt;
    logic [IN_WIDTH-1:0] r_dado;
    logic [IN_WIDTH-1:0] w_dado_nxt;
    logic                w_stall;
    logic                w_in_valido;
    logic                w_out_strobe;

    // Synchronizers and debouncer: a level change is accepted only after it
    // has been seen on every one of DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_botao_m  <= 1'b0;
            r_botao_s  <= 1'b0;
            r_sw_m     <= '0;
            r_sw_s     <= '0;
            r_cnt      <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
        end else begin
            r_botao_m  <= io.botao;
            r_botao_s  <= r_botao_m;
            r_sw_m     <= io.switches;
            r_sw_s     <= r_sw_m;
            r_btn_db_q <= r_btn_db;
            if (r_botao_s == r_btn_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_btn_db <= r_botao_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign w_btn_press = r_btn_db & ~r_btn_db_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_st_exec;
            r_tipo_in <= 1'b0;
            r_dado    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tipo_in <= w_tipo_nxt;
            r_dado    <= w_dado_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tipo_nxt   = r_tipo_in;
        w_dado_nxt   = r_dado;
        w_stall      = 1'b0;
        w_in_valido  = 1'b0;
        w_out_strobe = 1'b0;
        case (r_state)
            c_st_exec: begin
                // Decode outputs are Mealy so the request cycle itself is held.
                if (io.halt_req) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_st_parado;
                end else if (io.in_req) begin
                    w_stall     = 1'b1;
                    w_tipo_nxt  = 1'b1;
                    w_state_nxt = c_st_espera;
                end else if (io.out_req) begin
                    w_out_strobe = 1'b1;
                    if (PAUSE_ON_OUT) begin
                        w_stall     = 1'b1;
                        w_tipo_nxt  = 1'b0;
                        w_state_nxt = c_st_espera;
                    end
                end
            end
            c_st_espera: begin
                w_stall = 1'b1;
                if (w_btn_press) begin
                    if (r_tipo_in) begin
                        w_dado_nxt = IN_WIDTH'(r_sw_s);
                    end
                    w_state_nxt = c_st_libera;
                end
            end
            c_st_libera: begin
                // Exactly one released instruction, regardless of in_req.
                w_in_valido = r_tipo_in;
                w_state_nxt = c_st_exec;
            end
            c_st_parado: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_exec;
            end
        endcase
    end

    assign io.stall      = w_stall;
    assign io.in_valido  = w_in_valido;
    assign io.out_strobe = w_out_strobe;
    assign io.dado_in    = r_dado;
    assign io.halted     = (r_state == c_st_parado);
    assign io.estado     = r_state;

endmodule
`default_nettype wire
